// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack/TOS sequencer: opcodes, FSM states,
// datapath select/strobe encodings and the per-state strobe decode.
package stack_seq_pkg;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_PUSH_ARG  = 3'b001;
    localparam logic [2:0] OP_PUSH_DATA = 3'b010;
    localparam logic [2:0] OP_PUSH_ALU  = 3'b011;
    localparam logic [2:0] OP_POP       = 3'b100;
    localparam logic [2:0] OP_LOAD      = 3'b101;
    localparam logic [2:0] OP_STORE     = 3'b110;
    localparam logic [2:0] OP_RST_SP    = 3'b111;

    localparam logic [1:0] SRC_ALU    = 2'b00;
    localparam logic [1:0] SRC_MEMEXT = 2'b01;
    localparam logic [1:0] SRC_DATA   = 2'b10;
    localparam logic [1:0] SRC_ARG    = 2'b11;

    localparam logic [1:0] REG_NONE = 2'b00;
    localparam logic [1:0] REG_RD   = 2'b01;
    localparam logic [1:0] REG_WR   = 2'b10;
    localparam logic [1:0] REG_RW   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NOP,
        S_PLD,
        S_PWR,
        S_PINC,
        S_DEC,
        S_RWAIT,
        S_RLD,
        S_ADR,
        S_MWAIT,
        S_MLD,
        S_MWL,
        S_MWR,
        S_RSP,
        S_REJ
    } state_t;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] sel_mux_stack;
        logic [1:0] ctrl_reg_stack;
        logic [1:0] ctrl_reg_mem_ext;
        logic       sel_mux_tos;
        logic       ctrl_reg_tos;
        logic       ctrl_stack;
        logic       ctrl_mem_ext;
        logic       ctrl_reg_addr;
    } strobe_t;

    // Stack-write source for the push leg; LOAD pushes the mem-ext read register.
    function automatic logic [1:0] push_src(input logic [2:0] op);
        logic [1:0] src;
        case (op)
            OP_PUSH_ARG:  src = SRC_ARG;
            OP_PUSH_DATA: src = SRC_DATA;
            OP_LOAD:      src = SRC_MEMEXT;
            default:      src = SRC_ALU;
        endcase
        return src;
    endfunction

    // Strobe pattern for a state; op disambiguates the shared push/pop legs.
    function automatic strobe_t decode_strobes(input state_t st, input logic [2:0] op);
        strobe_t s;
        s = '0;
        case (st)
            S_NOP:   s.done = 1'b1;
            S_PLD: begin
                s.sel_mux_stack  = push_src(op);
                s.ctrl_reg_stack = REG_WR;
            end
            S_PWR: begin
                s.sel_mux_stack = push_src(op);
                s.ctrl_stack    = 1'b1;
            end
            S_PINC: begin
                s.sel_mux_stack = push_src(op);
                s.sel_mux_tos   = 1'b1;
                s.ctrl_reg_tos  = 1'b1;
                s.done          = 1'b1;
            end
            S_DEC: begin
                s.sel_mux_tos  = 1'b1;
                s.ctrl_reg_tos = 1'b1;
            end
            S_RLD: begin
                s.ctrl_reg_stack = REG_RD;
                s.done           = (op == OP_POP);
            end
            S_ADR:   s.ctrl_reg_addr    = 1'b1;
            S_MLD:   s.ctrl_reg_mem_ext = REG_RD;
            S_MWL:   s.ctrl_reg_mem_ext = REG_WR;
            S_MWR: begin
                s.ctrl_mem_ext = 1'b1;
                s.done         = 1'b1;
            end
            S_RSP: begin
                s.sel_mux_tos  = 1'b1;
                s.ctrl_reg_tos = 1'b1;
                s.done         = 1'b1;
            end
            S_REJ:   s.err = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack entry counter with increment/decrement/clear and full/empty flags.
module stack_depth_tracker #(
    parameter int DEPTH_WIDTH = 13,
    parameter int STACK_DEPTH = 4096
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   inc_i,
    input  logic                   dec_i,
    input  logic                   clr_i,
    output logic [DEPTH_WIDTH-1:0] depth_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(STACK_DEPTH);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

    logic [DEPTH_WIDTH-1:0] depth_q;

    // Count entries; clear has priority, simultaneous inc/dec cancel.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            depth_q <= '0;
        end else if (clr_i) begin
            depth_q <= '0;
        end else if (inc_i && !dec_i) begin
            depth_q <= depth_q + DEPTH_ONE;
        end else if (dec_i && !inc_i) begin
            depth_q <= depth_q - DEPTH_ONE;
        end
    end

    assign depth_o = depth_q;
    assign full_o  = (depth_q == DEPTH_MAX);
    assign empty_o = (depth_q == '0);

endmodule

// File: rtl/stack_tos_sequencer.sv
// Stack/TOS datapath sequencer: push, pop, external load/store, SP reset.
// Optional build macro STACK_SEQ_GUARD_EN rejects pushes when full and
// pops when empty with an err pulse; otherwise depth saturates silently.
module stack_tos_sequencer
    import stack_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd_op,
    output logic                  cmd_ready,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   depth,
    input  logic [ADDR_WIDTH-1:0] tos_in,
    output logic [ADDR_WIDTH-1:0] tos_return,
    output logic [1:0]            SEL_MUX_STACK,
    output logic [1:0]            CTRL_REG_STACK,
    output logic [1:0]            CTRL_REG_MEM_EXT,
    output logic                  SEL_MUX_TOS,
    output logic                  CTRL_REG_TOS,
    output logic                  CTRL_STACK,
    output logic                  CTRL_MEM_EXT,
    output logic                  CTRL_REG_ADDR
);

    localparam logic [ADDR_WIDTH-1:0] TOS_ONE = ADDR_WIDTH'(1);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    strobe_t    strb_q;
    logic       cmd_ready_q;
    logic       busy_q;
    logic       accept;
    logic       reject;
    logic       full, empty;
    logic       depth_inc, depth_dec, depth_clr;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef STACK_SEQ_GUARD_EN
    assign reject = (((cmd_op == OP_PUSH_ARG) || (cmd_op == OP_PUSH_DATA) ||
                      (cmd_op == OP_PUSH_ALU) || (cmd_op == OP_LOAD)) && full) ||
                    (((cmd_op == OP_POP) || (cmd_op == OP_STORE)) && empty);
`else
    assign reject = 1'b0;
`endif

    // Next-state: command dispatch in IDLE, then fixed walks through each leg.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = cmd_op;
                    if (reject) begin
                        state_d = S_REJ;
                    end else begin
                        case (cmd_op)
                            OP_NOP:                               state_d = S_NOP;
                            OP_PUSH_ARG, OP_PUSH_DATA, OP_PUSH_ALU: state_d = S_PLD;
                            OP_POP:                               state_d = S_DEC;
                            OP_LOAD, OP_STORE:                    state_d = S_ADR;
                            default:                              state_d = S_RSP;
                        endcase
                    end
                end
            end
            S_PLD:   state_d = S_PWR;
            S_PWR:   state_d = S_PINC;
            S_DEC:   state_d = S_RWAIT;
            S_RWAIT: state_d = S_RLD;
            S_RLD:   state_d = (op_q == OP_STORE) ? S_MWL : S_IDLE;
            S_ADR:   state_d = (op_q == OP_LOAD) ? S_MWAIT : S_DEC;
            S_MWAIT: state_d = S_MLD;
            S_MLD:   state_d = S_PLD;
            S_MWL:   state_d = S_MWR;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched opcode and registered strobes decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            strb_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            strb_q      <= decode_strobes(state_d, op_d);
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Next TOS value for the datapath mux; zero whenever the mux ignores it.
    always_comb begin
        tos_return = '0;
        case (state_q)
            S_PINC:  tos_return = tos_in + TOS_ONE;
            S_DEC:   tos_return = tos_in - TOS_ONE;
            default: tos_return = '0;
        endcase
    end

    // Gating with full/empty keeps the count saturated when rejection is off.
    assign depth_inc = (state_q == S_PINC) && !full;
    assign depth_dec = (state_q == S_RLD) && !empty;
    assign depth_clr = (state_q == S_RSP);

    stack_depth_tracker #(
        .DEPTH_WIDTH (ADDR_WIDTH + 1),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_depth (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (depth_inc),
        .dec_i   (depth_dec),
        .clr_i   (depth_clr),
        .depth_o (depth),
        .full_o  (full),
        .empty_o (empty)
    );

    assign cmd_ready        = cmd_ready_q;
    assign busy             = busy_q;
    assign done             = strb_q.done;
    assign err              = strb_q.err;
    assign SEL_MUX_STACK    = strb_q.sel_mux_stack;
    assign CTRL_REG_STACK   = strb_q.ctrl_reg_stack;
    assign CTRL_REG_MEM_EXT = strb_q.ctrl_reg_mem_ext;
    assign SEL_MUX_TOS      = strb_q.sel_mux_tos;
    assign CTRL_REG_TOS     = strb_q.ctrl_reg_tos;
    assign CTRL_STACK       = strb_q.ctrl_stack;
    assign CTRL_MEM_EXT     = strb_q.ctrl_mem_ext;
    assign CTRL_REG_ADDR    = strb_q.ctrl_reg_addr;

endmodule

// File: tb/tb_stack_tos_sequencer.sv
// Scoreboard bench for stack_tos_sequencer: the stimulus queues the expected
// per-cycle strobe trace of each command; a monitor compares every cycle.
module tb_stack_tos_sequencer;
    import stack_seq_pkg::*;

    localparam int AW = 12;
    localparam int SD = 8;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic          cmd_ready;
    logic          done;
    logic          err;
    logic          busy;
    logic [AW:0]   depth;
    logic [AW-1:0] tos_in;
    logic [AW-1:0] tos_return;
    logic [1:0]    SEL_MUX_STACK;
    logic [1:0]    CTRL_REG_STACK;
    logic [1:0]    CTRL_REG_MEM_EXT;
    logic          SEL_MUX_TOS;
    logic          CTRL_REG_TOS;
    logic          CTRL_STACK;
    logic          CTRL_MEM_EXT;
    logic          CTRL_REG_ADDR;

    stack_tos_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_op           (cmd_op),
        .cmd_ready        (cmd_ready),
        .done             (done),
        .err              (err),
        .busy             (busy),
        .depth            (depth),
        .tos_in           (tos_in),
        .tos_return       (tos_return),
        .SEL_MUX_STACK    (SEL_MUX_STACK),
        .CTRL_REG_STACK   (CTRL_REG_STACK),
        .CTRL_REG_MEM_EXT (CTRL_REG_MEM_EXT),
        .SEL_MUX_TOS      (SEL_MUX_TOS),
        .CTRL_REG_TOS     (CTRL_REG_TOS),
        .CTRL_STACK       (CTRL_STACK),
        .CTRL_MEM_EXT     (CTRL_MEM_EXT),
        .CTRL_REG_ADDR    (CTRL_REG_ADDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {done, err, sel_stack, reg_stack, reg_memext, sel_tos, reg_tos, stack_wr, memext_wr, reg_addr, tos_return}
    logic [24:0] act_w;
    assign act_w = {done, err, SEL_MUX_STACK, CTRL_REG_STACK, CTRL_REG_MEM_EXT,
                    SEL_MUX_TOS, CTRL_REG_TOS, CTRL_STACK, CTRL_MEM_EXT, CTRL_REG_ADDR, tos_return};

    typedef struct {
        logic [24:0] w;
        bit          last;
        logic [AW:0] dep;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [AW:0] mdl_depth;
    bit          pend;
    logic [AW:0] pend_dep;

    function automatic logic [24:0] mk(input logic dn, input logic er, input logic [1:0] sel,
                                       input logic [1:0] rs, input logic [1:0] rm,
                                       input logic st, input logic rt, input logic cs,
                                       input logic cm, input logic ra, input logic [AW-1:0] tr);
        return {dn, er, sel, rs, rm, st, rt, cs, cm, ra, tr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expq(input logic [24:0] w, input bit last, input logic [AW:0] dep);
        exp_t e;
        e.w = w; e.last = last; e.dep = dep;
        sb.push_back(e);
    endtask

    // Queue the expected trace for one command, then drive it through the handshake.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] t, input bit wait_end);
        int          n;
        bit          rej;
        logic [AW:0] nd;
        logic [1:0]  src;
        logic [AW-1:0] tm1, tp1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
            return;
        end
        tm1 = t - 12'd1;
        tp1 = t + 12'd1;
        nd  = mdl_depth;
        rej = 1'b0;
`ifdef STACK_SEQ_GUARD_EN
        if ((op inside {OP_PUSH_ARG, OP_PUSH_DATA, OP_PUSH_ALU, OP_LOAD}) && mdl_depth == SD) rej = 1'b1;
        if ((op inside {OP_POP, OP_STORE}) && mdl_depth == 0) rej = 1'b1;
`endif
        if (rej) begin
            expq(mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 12'h000), 1'b1, mdl_depth);
        end else begin
            case (op)
                OP_NOP: expq(mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 12'h000), 1'b1, mdl_depth);
                OP_PUSH_ARG, OP_PUSH_DATA, OP_PUSH_ALU, OP_LOAD: begin
                    nd  = (mdl_depth == SD) ? mdl_depth : mdl_depth + 1'b1;
                    src = (op == OP_PUSH_ARG) ? 2'b11 : (op == OP_PUSH_DATA) ? 2'b10 :
                          (op == OP_PUSH_ALU) ? 2'b00 : 2'b01;
                    if (op == OP_LOAD) begin
                        expq(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 12'h000), 1'b0, nd);
                        expq(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 12'h000), 1'b0, nd);
                        expq(mk(0, 0, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 12'h000), 1'b0, nd);
                    end
                    expq(mk(0, 0, src, 2'b10, 2'b00, 0, 0, 0, 0, 0, 12'h000), 1'b0, nd);
                    expq(mk(0, 0, src, 2'b00, 2'b00, 0, 0, 1, 0, 0, 12'h000), 1'b0, nd);
                    expq(mk(1, 0, src, 2'b00, 2'b00, 1, 1, 0, 0, 0, tp1), 1'b1, nd);
                end
                OP_POP, OP_STORE: begin
                    nd = (mdl_depth == 0) ? mdl_depth : mdl_depth - 1'b1;
                    if (op == OP_STORE)
                        expq(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 12'h000), 1'b0, nd);
                    expq(mk(0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, tm1), 1'b0, nd);
                    expq(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 12'h000), 1'b0, nd);
                    expq(mk(op == OP_POP, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 12'h000), op == OP_POP, nd);
                    if (op == OP_STORE) begin
                        expq(mk(0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 12'h000), 1'b0, nd);
                        expq(mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 12'h000), 1'b1, nd);
                    end
                end
                default: begin
                    nd = '0;
                    expq(mk(1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 12'h000), 1'b1, nd);
                end
            endcase
        end
        mdl_depth = nd;
        cmd_valid = 1'b1;
        cmd_op    = op;
        tos_in    = t;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        if (wait_end) begin
            n = 0;
            while ((sb.size() != 0 || pend) && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("cmd_complete", sb.size() + (pend ? 1 : 0), 32'd0);
        end
    endtask

    // Monitor: every busy cycle consumes one expected trace word; idle cycles must be quiet.
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                chk("depth_after_cmd", 32'(depth), 32'(pend_dep));
                pend = 1'b0;
            end
            if (busy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_busy: strobes %0h with no command queued at %0t", act_w, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("strobe_trace", 32'(act_w), 32'(e.w));
                    chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
                    if (e.last) begin
                        pend     = 1'b1;
                        pend_dep = e.dep;
                    end
                end
            end else begin
                chk("idle_strobes", 32'(act_w), 32'd0);
                chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        tos_in    = '0;
        mdl_depth = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'(act_w), 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(OP_PUSH_ARG, 12'd5, 1);
        issue(OP_POP, 12'd6, 1);
        issue(OP_POP, 12'd3, 1);          // empty-stack pop
        issue(OP_NOP, 12'd0, 1);
        issue(OP_PUSH_DATA, 12'd10, 1);
        issue(OP_PUSH_ALU, 12'hFFF, 1);   // TOS increment wraps to 0
        issue(OP_LOAD, 12'h040, 1);
        issue(OP_STORE, 12'd3, 1);
        issue(OP_POP, 12'h000, 1);        // TOS decrement wraps to FFF
        for (int i = 0; i < 6; i++) issue(OP_PUSH_ALU, 12'(100 + i), 1);
        chk("depth_before_rst_sp", 32'(depth), 32'd7);
        issue(OP_RST_SP, 12'hABC, 1);
        for (int i = 0; i < SD; i++) issue((i % 2 == 1) ? OP_PUSH_DATA : OP_LOAD, 12'(i * 3), 1);
        chk("depth_full", 32'(depth), 32'(SD));
        issue(OP_PUSH_ARG, 12'd7, 1);     // push at full
        issue(OP_LOAD, 12'd8, 1);         // load at full
        issue(OP_STORE, 12'd9, 1);
        issue(OP_POP, 12'd20, 1);

        // Reset asserted while a LOAD sits in its memory-wait state.
        issue(OP_LOAD, 12'h020, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        mdl_depth = '0;
        #1;
        chk("rst_mid_strobes", 32'(act_w), 32'd0);
        chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_depth", 32'(depth), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_strobes", 32'(act_w), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(OP_PUSH_ARG, 12'd1, 1);
        issue(OP_STORE, 12'd2, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
